axi_lite_sram_slave: RTL
========================

// Module: axi_lite_sram_slave
// PURPOSE
// - AXI4-Lite responder (slave end) for the IFU/LSU initiator ports; one instance serves one initiator.
// - Word-addressed on-chip SRAM model with independent read and write channels.
// - Configurable, optionally randomised response latency, so initiators are exercised against multi-cycle memory.
// PARAMETERS
// ADDR_BASE    32'h8000_0000  byte address of word 0
// DEPTH        4096           number of 32-bit words; power of 2
// RD_LAT       1              cycles from AR handshake to rvalid; >=1
// WR_LAT       1              cycles from AW+W both captured to bvalid; >=1
// RAND_DELAY   0              1: add 0..15 extra cycles per transaction, from a 4-bit LFSR
// PORTS
// clk      in   1   clock, all logic on posedge
// rst      in   1   reset, synchronous, active-low
// araddr   in   32  read byte address
// arvalid  in   1   read address valid
// arready  out  1   read address accepted
// rdata    out  32  read data
// rresp    out  2   read response: OKAY=2'b00, DECERR=2'b11
// rvalid   out  1   read data valid
// rready   in   1   initiator accepts read data
// awaddr   in   32  write byte address
// awvalid  in   1   write address valid
// awready  out  1   write address accepted
// wdata    in   32  write data
// wstrb    in   4   byte enables; bit i -> wdata[8i+7:8i]
// wvalid   in   1   write data valid
// wready   out  1   write data accepted
// bresp    out  2   write response, same encoding as rresp
// bvalid   out  1   write response valid
// bready   in   1   initiator accepts write response
// BEHAVIOUR
// - Reset (rst==0 at posedge): FSMs -> IDLE; arready/awready/wready=0, rvalid/bvalid=0, rdata=0, rresp/bresp=OKAY.
//   In-flight transactions are dropped; an uncommitted write never reaches the array. Array contents are not reset. LFSR seed = 4'b1001.
// - Read FSM R_IDLE -> R_WAIT -> R_RESP:
//   - R_IDLE: arready=1. arvalid&arready latches araddr and loads cnt=RD_LAT-1 (+lfsr if RAND_DELAY).
//   - R_WAIT: decrements cnt. At cnt==0, rdata/rresp are sampled from the array and state -> R_RESP.
//   - R_RESP: rvalid=1; rdata/rresp held stable until rready. Handshake -> R_IDLE. No new AR accepted before then (single outstanding).
//   - RD_LAT=1, no random delay: rvalid is asserted 1 cycle after the AR handshake.
// - Write FSM W_IDLE -> W_WAIT -> W_RESP:
//   - W_IDLE: awready=~aw_got, wready=~w_got. AW and W may arrive in either order or in the same cycle; each is latched independently.
//   - When both have been captured: load cnt=WR_LAT-1 (+lfsr), -> W_WAIT.
//   - W_WAIT: at cnt==0, commit the strobed bytes to the array and -> W_RESP.
//   - W_RESP: bvalid=1 until bready. Handshake clears aw_got/w_got and -> W_IDLE.
// - Address decode: idx = (addr-ADDR_BASE)>>2; addr[1:0] ignored.
//   Out of range (addr<ADDR_BASE or idx>=DEPTH): DECERR, rdata=32'h0, write suppressed.
// - wstrb=4'b0000 is legal: OKAY response, array unchanged.
// - Same-cycle read sample and write commit to the same word: the read returns the OLD data (no forwarding).
// - The two channels are fully independent; either channel stalling never blocks the other.
// - The LFSR (x^4+x^3+1) advances once per accepted transaction on either channel.
// - Address subtraction is 32-bit unsigned; a borrow flags out-of-range.
// STRUCTURE
// - axi_lite_pkg: resp_t codes (OKAY, SLVERR, DECERR), state enums r_state_t/w_state_t.
// - Sub-module lfsr_delay (4-bit LFSR, en -> next value). Array and both FSMs are inline.
// TESTING
// 1. Reset, then AR 0x8000_0000 after a prior write of 0xDEAD_BEEF there, RD_LAT=1:
//    rvalid 1 cycle after the handshake, rdata=0xDEAD_BEEF, rresp=00.
// 2. Write 0x1122_3344, wstrb=4'b0101, to a word holding 0xAABB_CCDD; read back -> 0xAA22_CC44, bresp=00.
// 3. W presented 3 cycles before AW: wready drops after the W capture;
//    bvalid WR_LAT cycles after the AW capture; then a read returns the new data.
// 4. Read at ADDR_BASE+4*DEPTH and at 0x7FFF_FFFC: rresp=11, rdata=0. Write there: bresp=11, array unchanged.
// 5. rready held low 5 cycles in R_RESP: rvalid/rdata stable, arready=0;
//    meanwhile a write completes normally.
// 6. rst driven low while in W_WAIT: next cycle bvalid=0, FSM idle, target word unchanged.
//    RAND_DELAY=1 soak: 1000 random transactions compared against a reference model.

Source files
------------

// File: rtl/axi_lite_sram_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave_pkg
// Shared types for the AXI4-Lite SRAM responder:
//   resp_t       - AXI response codes carried on rresp/bresp
//   r_state_t    - read channel FSM states
//   w_state_t    - write channel FSM states
//   CNT_W        - width of the latency down-counters
//   LFSR_SEED    - reset value of the delay LFSR
//   lfsr4_next() - one step of the x^4+x^3+1 LFSR
// -----------------------------------------------------------------------------
package axi_lite_sram_slave_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    localparam int         CNT_W     = 16;
    localparam logic [3:0] LFSR_SEED = 4'b1001;

    // Fibonacci form of x^4+x^3+1: maximal length, never reaches zero from a non-zero seed.
    function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave_if
// AXI4-Lite bus bundle between one initiator and the SRAM responder.
//   AR: araddr/arvalid/arready     R: rdata/rresp/rvalid/rready
//   AW: awaddr/awvalid/awready     W: wdata/wstrb/wvalid/wready
//   B : bresp/bvalid/bready
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where valid and ready are both high; valid, once raised, holds its payload
// stable until that edge, and ready never depends combinationally on valid.
// -----------------------------------------------------------------------------
interface axi_lite_sram_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_sram_slave_lfsr_delay.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave_lfsr_delay
// 4-bit LFSR supplying 0..15 extra cycles of response latency.
//   clk    in  clock
//   rst    in  synchronous active-low reset (loads LFSR_SEED)
//   n_adv  in  number of steps to advance this cycle (0, 1 or 2)
//   value  out current LFSR state
// Two steps are needed when a read and a write start in the same cycle.
// -----------------------------------------------------------------------------
module axi_lite_sram_slave_lfsr_delay
    import axi_lite_sram_slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] n_adv,
    output logic [3:0] value
);

    logic [3:0] lfsr_q, lfsr_d, step1;

    always_comb begin
        step1  = lfsr4_next(lfsr_q);
        lfsr_d = lfsr_q;
        case (n_adv)
            2'd1:    lfsr_d = step1;
            2'd2:    lfsr_d = lfsr4_next(step1);
            default: lfsr_d = lfsr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave
// AXI4-Lite responder backed by a word-addressed SRAM model, with independent
// read and write channels and configurable (optionally randomised) latency.
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous active-low reset
//   bus          slave modport of axi_lite_sram_slave_if (AR/R/AW/W/B)
//   dbg_r_state  out  read FSM state
//   dbg_w_state  out  write FSM state
// Out-of-range addresses return DECERR with zero read data; writes to them
// are dropped. Array contents are not reset.
// -----------------------------------------------------------------------------
module axi_lite_sram_slave
    import axi_lite_sram_slave_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          DEPTH      = 4096,
    parameter int          RD_LAT     = 1,
    parameter int          WR_LAT     = 1,
    parameter bit          RAND_DELAY = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_sram_slave_if.slave    bus,
    output r_state_t                dbg_r_state,
    output w_state_t                dbg_w_state
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    // Offset subtraction is unsigned; a borrow (addr below base) is out of range.
    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a >= ADDR_BASE) && ({2'b00, off[31:2]} < 32'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off[IDX_W+1:2];
    endfunction

    logic [3:0]       lfsr_val;
    logic             r_start, w_start;
    logic [CNT_W-1:0] r_load, w_load;

    axi_lite_sram_slave_lfsr_delay u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .n_adv ({1'b0, r_start} + {1'b0, w_start}),
        .value (lfsr_val)
    );

    assign r_load = CNT_W'(RD_LAT - 1) + (RAND_DELAY ? CNT_W'(lfsr_val) : CNT_W'(0));
    assign w_load = CNT_W'(WR_LAT - 1) + (RAND_DELAY ? CNT_W'(lfsr_val) : CNT_W'(0));

    // ---------------- read channel ----------------
    r_state_t         r_state_q, r_state_d;
    logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
    logic [31:0]      r_addr_q, r_addr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_addr_d  = r_addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_start   = 1'b0;
        case (r_state_q)
            R_IDLE: if (bus.arvalid && arready_q) begin
                r_addr_d  = bus.araddr;
                r_cnt_d   = r_load;
                r_start   = 1'b1;
                r_state_d = R_WAIT;
            end
            R_WAIT: if (r_cnt_q == '0) begin
                // Sampled before any same-edge write commit lands: old data wins.
                if (in_range(r_addr_q)) begin
                    rdata_d = mem[word_idx(r_addr_q)];
                    rresp_d = RESP_OKAY;
                end else begin
                    rdata_d = 32'h0;
                    rresp_d = RESP_DECERR;
                end
                r_state_d = R_RESP;
            end else begin
                r_cnt_d = r_cnt_q - 1'b1;
            end
            R_RESP: if (rvalid_q && bus.rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_addr_q  <= r_addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // ---------------- write channel ----------------
    w_state_t         w_state_q, w_state_d;
    logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
    logic [31:0]      w_addr_q, w_addr_d;
    logic [31:0]      wbuf_q, wbuf_d;
    logic [3:0]       wstrb_buf_q, wstrb_buf_d;
    logic             aw_got_q, aw_got_d;
    logic             w_got_q, w_got_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic             mem_we;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        w_state_d   = w_state_q;
        w_cnt_d     = w_cnt_q;
        w_addr_d    = w_addr_q;
        wbuf_d      = wbuf_q;
        wstrb_buf_d = wstrb_buf_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        bresp_d     = bresp_q;
        w_start     = 1'b0;
        mem_we      = 1'b0;
        w_idx       = word_idx(w_addr_q);
        case (w_state_q)
            W_IDLE: begin
                // AW and W are captured independently, in any order.
                if (bus.awvalid && awready_q) begin
                    aw_got_d = 1'b1;
                    w_addr_d = bus.awaddr;
                end
                if (bus.wvalid && wready_q) begin
                    w_got_d     = 1'b1;
                    wbuf_d      = bus.wdata;
                    wstrb_buf_d = bus.wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    w_cnt_d   = w_load;
                    w_start   = 1'b1;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: if (w_cnt_q == '0) begin
                // rst gates the commit so a write caught by reset never lands.
                mem_we    = rst && in_range(w_addr_q);
                bresp_d   = in_range(w_addr_q) ? RESP_OKAY : RESP_DECERR;
                w_state_d = W_RESP;
            end else begin
                w_cnt_d = w_cnt_q - 1'b1;
            end
            W_RESP: if (bvalid_q && bus.bready) begin
                aw_got_d  = 1'b0;
                w_got_d   = 1'b0;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q   <= W_IDLE;
            w_cnt_q     <= '0;
            w_addr_q    <= '0;
            wbuf_q      <= '0;
            wstrb_buf_q <= '0;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            bresp_q     <= RESP_OKAY;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            w_cnt_q     <= w_cnt_d;
            w_addr_q    <= w_addr_d;
            wbuf_q      <= wbuf_d;
            wstrb_buf_q <= wstrb_buf_d;
            aw_got_q    <= aw_got_d;
            w_got_q     <= w_got_d;
            bresp_q     <= bresp_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_buf_q[b]) mem[w_idx][8*b +: 8] <= wbuf_q[8*b +: 8];
            end
        end
    end

    assign bus.arready = arready_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bresp   = bresp_q;
    assign bus.bvalid  = bvalid_q;
    assign dbg_r_state = r_state_q;
    assign dbg_w_state = w_state_q;

endmodule
